// File: rtl/imem_responder.sv
// Instruction-memory responder: fixed-latency, single-outstanding fetch port with a load port.
// Optional flush/redirect abort of a waiting request is enabled by defining IMEM_RESP_ABORT_EN.
package imem_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;
endpackage

// state  | meaning
// S_IDLE | no request outstanding, accepts ireq.valid
// S_WAIT | request latched, counting down latency
// S_RESP | one-cycle handshake with read data
module imem_responder
    import imem_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  ibus_req_t                    ireq,
    output ibus_resp_t                   iresp,
    input  logic                         load_en,
    input  logic [$clog2(MEM_WORDS)-1:0] load_addr,
    input  logic [31:0]                  load_data,
    output logic                         busy
);
    localparam int AW = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;

    logic [31:0]   mem [MEM_WORDS];
    logic [AW-1:0] word_idx;
    logic          addr_bad;
    logic          abort;

    assign word_idx = addr_q[2 +: AW];
    // Misaligned or beyond the array: answered with zero, normal timing.
    assign addr_bad = (addr_q[1:0] != 2'b00) || ((addr_q >> (AW + 2)) != 32'd0);

`ifdef IMEM_RESP_ABORT_EN
    assign abort = !ireq.valid || (ireq.addr != addr_q);
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (ireq.valid) begin
                    addr_d  = ireq.addr;
                    cnt_d   = 4'(LATENCY);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    data_d  = addr_bad ? 32'h0000_0000 : mem[word_idx];
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            data_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Memory survives reset; the read above sees the pre-edge word.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    always_comb begin
        iresp = '0;
        if (state_q == S_RESP) begin
            iresp.addr_ok = 1'b1;
            iresp.data_ok = 1'b1;
            iresp.data    = data_q;
        end
    end

    assign busy = (state_q != S_IDLE);
endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: cycle-count reference model plus directed scenarios with literal expectations.
module tb_imem_responder;
    import imem_pkg::*;

    localparam int MEM_WORDS = 1024;
    localparam int LATENCY   = 2;
    localparam int AW        = $clog2(MEM_WORDS);

    logic          clk;
    logic          reset;
    ibus_req_t     ireq;
    ibus_resp_t    iresp;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [31:0]   load_data;
    logic          busy;

    int checks = 0;
    int errors = 0;

    imem_responder #(.MEM_WORDS(MEM_WORDS), .LATENCY(LATENCY)) dut (
        .clk       (clk),
        .reset     (reset),
        .ireq      (ireq),
        .iresp     (iresp),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: counts remaining busy cycles of the outstanding request.
    logic [31:0] m_mem [MEM_WORDS];
    int          m_rem  = 0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_data = '0;
    bit          m_live = 0;

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a[1:0] != 2'b00 || a >= 32'(MEM_WORDS * 4)) return 32'h0;
        return m_mem[a[2 +: AW]];
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            m_rem  = 0;
            m_live = 1;
        end else if (m_rem == 0) begin
            if (ireq.valid) begin
                m_addr = ireq.addr;
                m_rem  = LATENCY + 2;
            end
        end else begin
`ifdef IMEM_RESP_ABORT_EN
            if (m_rem >= 2 && (!ireq.valid || ireq.addr != m_addr)) m_rem = 0;
            else begin
                if (m_rem == 2) m_data = model_read(m_addr);
                m_rem--;
            end
`else
            if (m_rem == 2) m_data = model_read(m_addr);
            m_rem--;
`endif
        end
        if (load_en) m_mem[load_addr] = load_data;
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("model_busy", 64'(busy), 64'(m_rem > 0));
            chk("model_iresp", 64'(iresp),
                64'({(m_rem == 1), (m_rem == 1), (m_rem == 1) ? m_data : 32'h0}));
        end
    end

    // Per-cycle recording for the directed scenarios.
    logic [33:0] resp_at [16];
    logic        busy_at [16];

    task automatic rec(input int c);
        #1;
        resp_at[c] = iresp;
        busy_at[c] = busy;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic window(input string name, input int n, input int exp_first,
                          input int exp_count, input logic [31:0] exp_data);
        int first = -1;
        int cnt   = 0;
        logic [31:0] d = 32'hFFFF_FFFF;
        for (int c = 0; c < n; c++) begin
            if (resp_at[c][32]) begin
                cnt++;
                if (first < 0) begin
                    first = c;
                    d     = resp_at[c][31:0];
                end
            end
        end
        chk({name, "_first_ok"}, 64'(first), 64'(exp_first));
        chk({name, "_ok_count"}, 64'(cnt), 64'(exp_count));
        chk({name, "_data"}, 64'(d), 64'(exp_data));
    endtask

    task automatic idle_gap();
        ireq    = '0;
        load_en = 1'b0;
        repeat (2) next_cycle();
    endtask

    task automatic do_load(input int idx, input logic [31:0] val);
        load_en   = 1'b1;
        load_addr = AW'(idx);
        load_data = val;
        next_cycle();
        load_en = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) m_mem[i] = 32'h0;
        reset     = 1'b0;
        ireq      = '0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        next_cycle();
        // Program load while reset is asserted.
        do_load(5, 32'h0050_0093);
        do_load(0, 32'h1111_1111);
        do_load(1, 32'h2222_2222);
        do_load(16, 32'hDEAD_BEEF);
        chk("reset_iresp", 64'(iresp), 64'h0);
        chk("reset_busy", 64'(busy), 64'h0);
        reset = 1'b1;
        next_cycle();

        // Basic fetch of 0x14.
        for (int c = 0; c < 7; c++) begin
            ireq.valid = (c <= 4);
            ireq.addr  = 32'h14;
            rec(c);
            next_cycle();
        end
        window("basic", 7, 4, 1, 32'h0050_0093);
        chk("basic_busy_c0", 64'(busy_at[0]), 64'h0);
        chk("basic_busy_c1", 64'(busy_at[1]), 64'h1);
        chk("basic_busy_c4", 64'(busy_at[4]), 64'h1);
        chk("basic_busy_c5", 64'(busy_at[5]), 64'h0);
        idle_gap();

        // Misaligned address and first out-of-range address.
        for (int c = 0; c < 6; c++) begin
            ireq.valid = (c <= 4);
            ireq.addr  = 32'h16;
            rec(c);
            next_cycle();
        end
        window("misaligned", 6, 4, 1, 32'h0);
        idle_gap();
        for (int c = 0; c < 6; c++) begin
            ireq.valid = (c <= 4);
            ireq.addr  = 32'(MEM_WORDS * 4);
            rec(c);
            next_cycle();
        end
        window("out_of_range", 6, 4, 1, 32'h0);
        idle_gap();

        // Back-to-back with valid held.
        for (int c = 0; c < 11; c++) begin
            ireq.valid = (c <= 9);
            ireq.addr  = (c <= 4) ? 32'h0 : 32'h4;
            rec(c);
            next_cycle();
        end
        window("b2b", 11, 4, 2, 32'h1111_1111);
        chk("b2b_second_ok", 64'(resp_at[9][32]), 64'h1);
        chk("b2b_second_data", 64'(resp_at[9][31:0]), 64'h2222_2222);
        chk("b2b_gap_c5", 64'(resp_at[5][32]), 64'h0);
        idle_gap();

        // Reset in cycle 2 of a request; valid held through reset.
        for (int c = 0; c < 9; c++) begin
            ireq.valid = (c <= 7);
            ireq.addr  = 32'h14;
            reset      = (c != 2);
            rec(c);
            next_cycle();
        end
        reset = 1'b1;
        window("reset_mid", 9, 7, 1, 32'h0050_0093);
        chk("reset_mid_iresp_c3", 64'(resp_at[3]), 64'h0);
        chk("reset_mid_busy_c3", 64'(busy_at[3]), 64'h0);
        idle_gap();

        // Address redirect 0x0 -> 0x40 in cycle 2.
        for (int c = 0; c < 11; c++) begin
            ireq.valid = (c <= 9);
            ireq.addr  = (c <= 1) ? 32'h0 : 32'h40;
            rec(c);
            next_cycle();
        end
`ifdef IMEM_RESP_ABORT_EN
        window("redirect", 11, 7, 1, 32'hDEAD_BEEF);
`else
        window("redirect", 11, 4, 2, 32'h1111_1111);
        chk("redirect_second_data", 64'(resp_at[9][31:0]), 64'hDEAD_BEEF);
`endif
        idle_gap();

        // Load colliding with the WAIT->RESP read of word 0.
        for (int c = 0; c < 11; c++) begin
            ireq.valid = (c <= 9);
            ireq.addr  = 32'h0;
            load_en    = (c == 3);
            load_addr  = '0;
            load_data  = 32'hAAAA_AAAA;
            rec(c);
            next_cycle();
        end
        window("rbw", 11, 4, 2, 32'h1111_1111);
        chk("rbw_next_data", 64'(resp_at[9][31:0]), 64'hAAAA_AAAA);
        idle_gap();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end
endmodule
